// File: rtl/mtsp_sf_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : mtsp_sf_issue_seq
// Brief    : Serialises a 4-lane SF micro-op bundle into one lane issue per
//            cycle (X,Y,Z,W order), back-pressuring upstream until done.
// Revision : 1.0 - initial release
// ============================================================================
module mtsp_sf_issue_seq #(
  parameter int MO_W = 8,
  parameter int DW   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [3:0]        IN_LANE_EN,
  input  logic [4*MO_W-1:0] IN_MO,
  input  logic [4*DW-1:0]   IN_SRC,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [1:0]        OUT_LANE,
  output logic [MO_W-1:0]   OUT_MO,
  output logic [DW-1:0]     OUT_DIN,
  output logic              OUT_LAST,
  output logic              DONE
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_rem, w_rem_nxt, w_rem_left;
  logic [4*MO_W-1:0] r_mo, w_mo_nxt;
  logic [4*DW-1:0]   r_src, w_src_nxt;

  logic              r_out_valid, r_out_last, r_done;
  logic [1:0]        r_out_lane;
  logic [MO_W-1:0]   r_out_mo;
  logic [DW-1:0]     r_out_din;

  logic              w_fire, w_in_ready, w_accept, w_done_nxt;
  logic [1:0]        w_sel_lane, w_nxt_lane;
  logic              w_nxt_valid, w_nxt_last;
  logic [MO_W-1:0]   w_nxt_mo;
  logic [DW-1:0]     w_nxt_din;

  // Highest set mask bit wins; bit3 is lane X (index 0).
  function automatic logic [1:0] lane_of(input logic [3:0] m);
    casez (m)
      4'b1???: lane_of = 2'd0;
      4'b01??: lane_of = 2'd1;
      4'b001?: lane_of = 2'd2;
      default: lane_of = 2'd3;
    endcase
  endfunction

  always_comb begin
    w_fire     = r_out_valid & OUT_READY;
    // Empty bundles are refused while issuing so their DONE cannot collide.
    w_in_ready = !FLUSH & ((r_state == ST_IDLE) |
                 ((r_state == ST_ISSUE) & r_out_last & OUT_READY & (|IN_LANE_EN)));
    w_accept   = IN_VALID & w_in_ready;
    w_sel_lane = lane_of(r_rem);
    w_rem_left = w_fire ? (r_rem & ~(4'b1000 >> w_sel_lane)) : r_rem;

    w_state_nxt = r_state;
    w_rem_nxt   = w_rem_left;
    w_mo_nxt    = r_mo;
    w_src_nxt   = r_src;
    w_done_nxt  = 1'b0;

    if (FLUSH) begin
      w_state_nxt = ST_IDLE;
      w_rem_nxt   = 4'd0;
    end else begin
      w_done_nxt = (w_fire & r_out_last) |
                   (w_accept & (r_state == ST_IDLE) & (IN_LANE_EN == 4'd0));
      if (w_accept) begin
        w_rem_nxt   = IN_LANE_EN;
        w_mo_nxt    = IN_MO;
        w_src_nxt   = IN_SRC;
        w_state_nxt = (|IN_LANE_EN) ? ST_ISSUE : ST_IDLE;
      end else begin
        w_state_nxt = (|w_rem_left) ? ST_ISSUE : ST_IDLE;
      end
    end
  end

  // Issue outputs are precomputed from next-cycle state so they leave flops.
  always_comb begin
    w_nxt_lane  = lane_of(w_rem_nxt);
    w_nxt_valid = |w_rem_nxt;
    w_nxt_last  = w_nxt_valid & ((w_rem_nxt & (w_rem_nxt - 4'd1)) == 4'd0);
    w_nxt_mo    = '0;
    w_nxt_din   = '0;
    if (w_nxt_valid) begin
      case (w_nxt_lane)
        2'd0: begin
          w_nxt_mo  = w_mo_nxt[4*MO_W-1 -: MO_W];
          w_nxt_din = w_src_nxt[4*DW-1 -: DW];
        end
        2'd1: begin
          w_nxt_mo  = w_mo_nxt[3*MO_W-1 -: MO_W];
          w_nxt_din = w_src_nxt[3*DW-1 -: DW];
        end
        2'd2: begin
          w_nxt_mo  = w_mo_nxt[2*MO_W-1 -: MO_W];
          w_nxt_din = w_src_nxt[2*DW-1 -: DW];
        end
        default: begin
          w_nxt_mo  = w_mo_nxt[MO_W-1:0];
          w_nxt_din = w_src_nxt[DW-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_rem       <= 4'd0;
      r_mo        <= '0;
      r_src       <= '0;
      r_out_valid <= 1'b0;
      r_out_lane  <= 2'd0;
      r_out_mo    <= '0;
      r_out_din   <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_mo        <= w_mo_nxt;
      r_src       <= w_src_nxt;
      r_out_valid <= w_nxt_valid;
      r_out_lane  <= w_nxt_valid ? w_nxt_lane : 2'd0;
      r_out_mo    <= w_nxt_mo;
      r_out_din   <= w_nxt_din;
      r_out_last  <= w_nxt_last;
      r_done      <= w_done_nxt;
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_VALID = r_out_valid;
  assign OUT_LANE  = r_out_lane;
  assign OUT_MO    = r_out_mo;
  assign OUT_DIN   = r_out_din;
  assign OUT_LAST  = r_out_last;
  assign DONE      = r_done;

endmodule
`default_nettype wire
